// File: rtl/mem_load_sched_pkg.sv
// rtl/mem_load_sched_pkg.sv - shared state encoding and default widths for mem_load_sched
package mem_load_sched_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_IF_WIDTH    = 16;
    localparam int DEF_KERNEL_SIZE = 9;
    localparam int DEF_CNT_WIDTH   = 6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACT_FLAG = 3'd1,
        S_ACT_DATA = 3'd2,
        S_WEI_FLAG = 3'd3,
        S_WEI_DATA = 3'd4,
        S_START    = 3'd5,
        S_RUN      = 3'd6,
        S_DONE     = 3'd7
    } state_t;

endpackage

// File: rtl/mem_load_sched_if.sv
// rtl/mem_load_sched_if.sv - input beat stream shared by the DMA/FIFO source and the scheduler
interface mem_load_sched_if
    import mem_load_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IF_WIDTH   = DEF_IF_WIDTH
);

    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH*IF_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/mem_load_sched_popcount_9.sv
// rtl/mem_load_sched_popcount_9.sv - combinational population count of a weight flag
module popcount_9 #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] bits,
    output logic [3:0]       count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + {3'd0, bits[i]};
        end
    end

endmodule

// File: rtl/mem_load_sched.sv
// rtl/mem_load_sched.sv - fills mem_controller from one stream, pulses start, waits for rows, signals done
// Optional perf counters are built when MEM_LOAD_SCHED_PERF_EN is defined.
module mem_load_sched
    import mem_load_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IF_WIDTH    = DEF_IF_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic                           cfg_mode,
    input  logic [CNT_WIDTH-1:0]           cfg_act_rows,
    input  logic [CNT_WIDTH-1:0]           cfg_wei_kernels,
    input  logic [CNT_WIDTH-1:0]           cfg_run_rows,
    mem_load_sched_if.slave                in_bus,
    output logic                           mode,
    output logic                           wr_req_act_flag,
    output logic [IF_WIDTH-1:0]            wr_data_act_flag,
    output logic [IF_WIDTH-1:0]            wr_req_act,
    output logic [DATA_WIDTH*IF_WIDTH-1:0] wr_data_act,
    output logic                           wr_req_wei_flag,
    output logic [KERNEL_SIZE-1:0]         wr_data_wei_flag,
    output logic                           wr_req_wei,
    output logic [DATA_WIDTH-1:0]          wr_data_wei,
    output logic                           start,
    input  logic                           row_cal_done,
    output logic                           busy,
    output logic                           done
`ifdef MEM_LOAD_SCHED_PERF_EN
    ,
    output logic [31:0]                    perf_stall_cycles,
    output logic [31:0]                    perf_run_cycles
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               state;
    logic [CNT_WIDTH-1:0] act_rows;
    logic [CNT_WIDTH-1:0] wei_kernels;
    logic [CNT_WIDTH-1:0] run_rows;
    logic [CNT_WIDTH-1:0] row_cnt;
    logic [CNT_WIDTH-1:0] kern_cnt;
    logic [CNT_WIDTH-1:0] wei_rem;
    logic [CNT_WIDTH-1:0] run_cnt;
    logic [3:0]           wei_pop;
    logic [CNT_WIDTH-1:0] wei_pop_ext;
    logic                 accept;
    logic                 kern_last;

    assign in_bus.in_ready = (state == S_ACT_FLAG) || (state == S_ACT_DATA) ||
                             (state == S_WEI_FLAG) || (state == S_WEI_DATA);
    assign cfg_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign accept      = in_bus.in_valid && in_bus.in_ready;
    assign wei_pop_ext = {{(CNT_WIDTH-4){1'b0}}, wei_pop};
    assign kern_last   = ((kern_cnt + CNT_ONE) == wei_kernels);

    popcount_9 #(.WIDTH(KERNEL_SIZE)) u_popcount (
        .bits  (in_bus.in_data[KERNEL_SIZE-1:0]),
        .count (wei_pop)
    );

    // wr_data_act_flag doubles as the lane-enable register for the following data beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            act_rows         <= '0;
            wei_kernels      <= '0;
            run_rows         <= '0;
            row_cnt          <= '0;
            kern_cnt         <= '0;
            wei_rem          <= '0;
            run_cnt          <= '0;
            mode             <= 1'b0;
            wr_req_act_flag  <= 1'b0;
            wr_data_act_flag <= '0;
            wr_req_act       <= '0;
            wr_data_act      <= '0;
            wr_req_wei_flag  <= 1'b0;
            wr_data_wei_flag <= '0;
            wr_req_wei       <= 1'b0;
            wr_data_wei      <= '0;
            start            <= 1'b0;
            done             <= 1'b0;
        end else begin
            wr_req_act_flag <= 1'b0;
            wr_req_act      <= '0;
            wr_req_wei_flag <= 1'b0;
            wr_req_wei      <= 1'b0;
            start           <= 1'b0;
            done            <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        act_rows    <= cfg_act_rows;
                        wei_kernels <= cfg_wei_kernels;
                        run_rows    <= cfg_run_rows;
                        mode        <= cfg_mode;
                        row_cnt     <= '0;
                        kern_cnt    <= '0;
                        run_cnt     <= '0;
                        wei_rem     <= '0;
                        if (cfg_act_rows != '0)         state <= S_ACT_FLAG;
                        else if (cfg_wei_kernels != '0) state <= S_WEI_FLAG;
                        else                            state <= S_START;
                    end
                end
                S_ACT_FLAG: begin
                    if (accept) begin
                        wr_req_act_flag  <= 1'b1;
                        wr_data_act_flag <= in_bus.in_data[IF_WIDTH-1:0];
                        state            <= S_ACT_DATA;
                    end
                end
                S_ACT_DATA: begin
                    if (accept) begin
                        wr_req_act  <= wr_data_act_flag;
                        wr_data_act <= in_bus.in_data;
                        row_cnt     <= row_cnt + CNT_ONE;
                        if ((row_cnt + CNT_ONE) != act_rows) state <= S_ACT_FLAG;
                        else if (wei_kernels != '0)          state <= S_WEI_FLAG;
                        else                                 state <= S_START;
                    end
                end
                S_WEI_FLAG: begin
                    if (accept) begin
                        wr_req_wei_flag  <= 1'b1;
                        wr_data_wei_flag <= in_bus.in_data[KERNEL_SIZE-1:0];
                        wei_rem          <= wei_pop_ext;
                        if (wei_pop == 4'd0) begin
                            kern_cnt <= kern_cnt + CNT_ONE;
                            state    <= kern_last ? S_START : S_WEI_FLAG;
                        end else begin
                            state <= S_WEI_DATA;
                        end
                    end
                end
                S_WEI_DATA: begin
                    if (accept) begin
                        wr_req_wei  <= 1'b1;
                        wr_data_wei <= in_bus.in_data[DATA_WIDTH-1:0];
                        wei_rem     <= wei_rem - CNT_ONE;
                        if (wei_rem == CNT_ONE) begin
                            kern_cnt <= kern_cnt + CNT_ONE;
                            state    <= kern_last ? S_START : S_WEI_FLAG;
                        end
                    end
                end
                S_START: begin
                    start <= 1'b1;
                    state <= (run_rows == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (row_cal_done) begin
                        run_cnt <= run_cnt + CNT_ONE;
                        if ((run_cnt + CNT_ONE) == run_rows) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_LOAD_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_run_cycles   <= '0;
        end else if (state == S_IDLE && cfg_valid) begin
            perf_stall_cycles <= '0;
            perf_run_cycles   <= '0;
        end else begin
            if (in_bus.in_ready && !in_bus.in_valid) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state == S_RUN)                      perf_run_cycles   <= perf_run_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_load_sched.md
Name: mem_load_sched

Overview:
- Sequences the fill of mem_controller storage from one shared input stream: activation flags and activations first, then weight flags and weights.
- After the fill completes it pulses start, counts row_cal_done pulses until the configured row count is reached, and then signals done.
- Sits between the DMA/input-FIFO stream and the wr_req_*/wr_data_*/start/mode ports of mem_controller.
- Owns all write-request timing, so no other block drives those ports.

Parameters:
- DATA_WIDTH, 8, bits per activation/weight value.
- IF_WIDTH, 16, activation lanes per row; width of the activation flag.
- KERNEL_SIZE, 9, weights per kernel; width of the weight flag.
- CNT_WIDTH, 6, width of all configuration counts and internal counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted; high only in IDLE.
- cfg_mode  in  1  mode latched for the job.
- cfg_act_rows  in  CNT_WIDTH  number of activation rows to load.
- cfg_wei_kernels  in  CNT_WIDTH  number of weight kernels to load.
- cfg_run_rows  in  CNT_WIDTH  number of row_cal_done pulses that end the job.
- in_valid  in  1  stream beat valid.
- in_ready  out  1  stream beat accepted.
- in_data  in  DATA_WIDTH*IF_WIDTH  stream beat.
- mode  out  1  latched cfg_mode.
- wr_req_act_flag  out  1  activation flag write strobe.
- wr_data_act_flag  out  IF_WIDTH  activation flag data.
- wr_req_act  out  IF_WIDTH  per-lane activation write strobe.
- wr_data_act  out  DATA_WIDTH*IF_WIDTH  packed lanes; lane i is at [i*DATA_WIDTH +: DATA_WIDTH].
- wr_req_wei_flag  out  1  weight flag write strobe.
- wr_data_wei_flag  out  KERNEL_SIZE  weight flag data.
- wr_req_wei  out  1  weight write strobe.
- wr_data_wei  out  DATA_WIDTH  weight data.
- start  out  1  one-cycle pulse to mem_controller.
- row_cal_done  in  1  row-complete pulse from the datapath.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0, except cfg_ready=1.
  - All counters and latched config are cleared.
  - Reset asserted mid-job aborts the job immediately; no done pulse is issued.
- FSM states: IDLE, ACT_FLAG, ACT_DATA, WEI_FLAG, WEI_DATA, START, RUN, DONE.
- IDLE: when cfg_valid is high, latch the config and mode.
  - Next state is ACT_FLAG if act_rows≠0.
  - Else WEI_FLAG if wei_kernels≠0.
  - Else START.
- in_ready = 1 only in ACT_FLAG, ACT_DATA, WEI_FLAG and WEI_DATA. A beat is consumed when in_valid && in_ready.
- ACT_FLAG:
  - A consumed beat's bits [IF_WIDTH-1:0] are registered as the lane flag.
  - Next cycle: wr_req_act_flag=1 and wr_data_act_flag=flag.
  - Go to ACT_DATA.
- ACT_DATA:
  - A consumed beat is registered.
  - Next cycle: wr_req_act=lane flag and wr_data_act=beat. Only lanes whose flag bit is set are strobed.
  - Increment the row counter. Go to ACT_FLAG, or, when the counter reaches act_rows, go to WEI_FLAG (or START if wei_kernels=0).
  - A flag of 0 still consumes its data beat, with wr_req_act=0.
- WEI_FLAG:
  - A consumed beat's bits [KERNEL_SIZE-1:0] are registered.
  - Next cycle: wr_req_wei_flag=1.
  - Load the remaining-weight counter with popcount(flag).
  - If popcount=0, count the kernel as done and skip WEI_DATA.
- WEI_DATA:
  - Each consumed beat yields wr_req_wei=1 and wr_data_wei=in_data[DATA_WIDTH-1:0] on the next cycle.
  - The remaining count decrements. At 0 the kernel counter increments.
  - Go to WEI_FLAG, or to START once the kernel count equals wei_kernels.
- Write latency: exactly 1 cycle from beat acceptance to strobe. Strobes are single-cycle and registered.
- Back-pressure: an in_valid gap holds the current state with no strobes issued.
- START:
  - start=1 for exactly one cycle.
  - The cycle before it carries the final write strobe, so start never coincides with a write.
  - Go to RUN, or to DONE if run_rows=0.
- RUN:
  - Count row_cal_done pulses.
  - When the count reaches run_rows, go to DONE. The terminal pulse is counted.
  - row_cal_done outside RUN is ignored.
- DONE: done=1 for one cycle, then IDLE. cfg_ready returns high in that IDLE cycle.
- cfg_valid outside IDLE is ignored.
- Counters saturate-compare with equality only. A CNT_WIDTH all-ones count is legal.

Optional Feature:
- Macro: MEM_LOAD_SCHED_PERF_EN.
- With the macro defined, the block adds output perf_stall_cycles [31:0] and output perf_run_cycles [31:0].
  - perf_stall_cycles counts cycles with in_ready && !in_valid.
  - perf_run_cycles counts cycles spent in RUN.
  - Both clear on cfg acceptance and on reset, and wrap modulo 2^32.
- Without the macro, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - The state encoding typedef (3-bit).
  - Default widths DATA_WIDTH/IF_WIDTH/KERNEL_SIZE, aligned with the global defines used by mem_controller.
- One sub-module: popcount_9, a combinational population count of KERNEL_SIZE bits to a 4-bit result. It is reusable by the weight path.

Test Plan:
1. Config act_rows=2, wei_kernels=1, run_rows=3; flags 0xFFFF and 0x0001; weight flag 0x1FF with 9 beats.
   - Expect 2 act_flag strobes, wr_req_act=0xFFFF then 0x0001, 9 wr_req_wei, start once, done after the 3rd row_cal_done.
2. Weight flag 0x000 followed by weight flag 0x005.
   - Expect no WEI_DATA for kernel 0, exactly 2 wr_req_wei for kernel 1, then start.
3. in_valid toggled 1/0 every cycle during ACT_DATA.
   - Expect strobes only 1 cycle after accepted beats, with no duplicate or dropped rows.
4. Config with all zero counts.
   - Expect start pulse, then done the next state, with no write strobes and in_ready never high.
5. reset asserted in WEI_DATA after 4 of 9 weights.
   - Expect outputs cleared asynchronously, cfg_ready=1, no done; a new job then runs cleanly.
6. row_cal_done pulsed in IDLE and during load.
   - Expect it ignored: RUN still requires the full run_rows pulses.
